// File: rtl/unidade_controle_multiciclo_pkg.sv
// Shared types and codes for the multicycle control unit:
// FSM states, opcodes, extensor/ULA/mux codes and the output bundle.
package unidade_controle_pkg;

    typedef enum logic [2:0] {
        E_BUSCA,
        E_DECODIFICA,
        E_EXECUTA,
        E_MEMORIA,
        E_ESCRITA,
        E_HALT,
        E_ERRO
    } estado_t;

    typedef enum logic [3:0] {
        C_NOP,
        C_ALU,
        C_LD,
        C_ST,
        C_BEQZ,
        C_JMP,
        C_JAL,
        C_HALT,
        C_INV
    } classe_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LUI  = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_BEQZ = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JAL  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] EXT_ZERO6   = 3'd0;
    localparam logic [2:0] EXT_SINAL6  = 3'd1;
    localparam logic [2:0] EXT_SINAL9  = 3'd2;
    localparam logic [2:0] EXT_SINAL12 = 3'd3;
    localparam logic [2:0] EXT_ALTO8   = 3'd4;

    localparam logic [2:0] ULA_ADD    = 3'd0;
    localparam logic [2:0] ULA_SUB    = 3'd1;
    localparam logic [2:0] ULA_AND    = 3'd2;
    localparam logic [2:0] ULA_OR     = 3'd3;
    localparam logic [2:0] ULA_PASSA_B = 3'd4;

    localparam logic [1:0] MUX_ULA = 2'b00;
    localparam logic [1:0] MUX_MD  = 2'b01;
    localparam logic [1:0] MUX_PC  = 2'b10;

    localparam logic [1:0] PC_MAIS1  = 2'b00;
    localparam logic [1:0] PC_DESVIO = 2'b01;
    localparam logic [1:0] PC_MANTEM = 2'b10;

    typedef struct packed {
        logic        mem_req;
        logic        mem_we;
        logic        mem_sel_dado;
        logic        ir_load;
        logic        pc_load;
        logic [1:0]  pc_sel;
        logic        br_hab_escrita;
        logic [2:0]  br_sel_e_sa;
        logic [2:0]  br_sel_sb;
        logic [2:0]  ex_controle;
        logic [11:0] ex_constante;
        logic [1:0]  mux_controle;
        logic [2:0]  ula_op;
        logic        halt;
        logic        erro;
    } saidas_t;

endpackage

// File: rtl/unidade_controle_multiciclo_if.sv
// Control-unit <-> datapath/memory bundle.
// master = control unit, slave = datapath side.
interface unidade_controle_multiciclo_if;

    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        ula_zero;
    logic        mem_req;
    logic        mem_we;
    logic        mem_sel_dado;
    logic        ir_load;
    logic        pc_load;
    logic [1:0]  pc_sel;
    logic        br_hab_escrita;
    logic [2:0]  br_sel_e_sa;
    logic [2:0]  br_sel_sb;
    logic [2:0]  ex_controle;
    logic [11:0] ex_constante;
    logic [1:0]  mux_controle;
    logic [2:0]  ula_op;
    logic        halt;
    logic        erro;

    modport master (
        input  mem_rdata, mem_ack, ula_zero,
        output mem_req, mem_we, mem_sel_dado, ir_load, pc_load, pc_sel,
        output br_hab_escrita, br_sel_e_sa, br_sel_sb,
        output ex_controle, ex_constante, mux_controle, ula_op,
        output halt, erro
    );

    modport slave (
        output mem_rdata, mem_ack, ula_zero,
        input  mem_req, mem_we, mem_sel_dado, ir_load, pc_load, pc_sel,
        input  br_hab_escrita, br_sel_e_sa, br_sel_sb,
        input  ex_controle, ex_constante, mux_controle, ula_op,
        input  halt, erro
    );

endinterface

// File: rtl/unidade_controle_multiciclo_decodificador.sv
// Combinational opcode decoder: ULA op, extensor mode,
// result-mux select and instruction class.
module decodificador_instrucao
    import unidade_controle_pkg::*;
(
    input  logic [3:0] i_opcode,
    output logic [2:0] o_ula_op,
    output logic [2:0] o_ex_controle,
    output logic [1:0] o_mux_controle,
    output classe_t    o_classe
);

    always_comb begin
        o_ula_op       = ULA_ADD;
        o_ex_controle  = EXT_ZERO6;
        o_mux_controle = MUX_ULA;
        o_classe       = C_INV;
        case (i_opcode)
            OP_NOP:  o_classe = C_NOP;
            OP_ADD:  o_classe = C_ALU;
            OP_SUB: begin
                o_classe = C_ALU;
                o_ula_op = ULA_SUB;
            end
            OP_AND: begin
                o_classe = C_ALU;
                o_ula_op = ULA_AND;
            end
            OP_OR: begin
                o_classe = C_ALU;
                o_ula_op = ULA_OR;
            end
            OP_ADDI: begin
                o_classe      = C_ALU;
                o_ex_controle = EXT_SINAL6;
            end
            OP_LUI: begin
                o_classe      = C_ALU;
                o_ula_op      = ULA_PASSA_B;
                o_ex_controle = EXT_ALTO8;
            end
            OP_LD: begin
                o_classe       = C_LD;
                o_ula_op       = ULA_PASSA_B;
                o_mux_controle = MUX_MD;
            end
            OP_ST:   o_classe = C_ST;
            OP_BEQZ: begin
                o_classe      = C_BEQZ;
                o_ex_controle = EXT_SINAL9;
            end
            OP_JMP: begin
                o_classe      = C_JMP;
                o_ex_controle = EXT_SINAL12;
            end
            OP_JAL: begin
                o_classe       = C_JAL;
                o_ex_controle  = EXT_SINAL12;
                o_mux_controle = MUX_PC;
            end
            OP_HALT: o_classe = C_HALT;
            default: o_classe = C_INV;
        endcase
    end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control FSM: fetch, decode, execute, memory, write-back.
// Every output is registered from the state being entered (Moore).
module unidade_controle_multiciclo
    import unidade_controle_pkg::*;
#(
    parameter int         MEM_TIMEOUT = 15,
    parameter logic [2:0] REG_LINK    = 3'd7
) (
    input logic clock,
    input logic reset_n,
    unidade_controle_multiciclo_if.master ctl
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMITE = CW'(MEM_TIMEOUT - 1);

    estado_t       r_estado, w_prox;
    logic [15:0]   r_ir, w_ir_prox;
    logic [CW-1:0] r_cnt, w_cnt_prox;
    saidas_t       r_saida, w_saida;
    logic          w_ack;
    classe_t       w_classe;
    logic [2:0]    w_ula_op, w_ex;
    logic [1:0]    w_mux;

    // ack only counts while our own request is on the bus
    assign w_ack     = ctl.mem_ack & r_saida.mem_req;
    assign w_ir_prox = (r_estado == E_BUSCA && w_ack) ? ctl.mem_rdata : r_ir;

    decodificador_instrucao u_dec (
        .i_opcode       (w_ir_prox[15:12]),
        .o_ula_op       (w_ula_op),
        .o_ex_controle  (w_ex),
        .o_mux_controle (w_mux),
        .o_classe       (w_classe)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado <= E_BUSCA;
            r_ir     <= '0;
            r_cnt    <= '0;
            r_saida  <= '0;
        end else begin
            r_estado <= w_prox;
            r_ir     <= w_ir_prox;
            r_cnt    <= w_cnt_prox;
            r_saida  <= w_saida;
        end
    end

    always_comb begin
        w_prox     = r_estado;
        w_cnt_prox = '0;
        w_saida    = '0;
        unique case (r_estado)
            E_BUSCA, E_MEMORIA: begin
                if (w_ack) begin
                    if (r_estado == E_BUSCA)
                        w_prox = E_DECODIFICA;
                    else if (w_classe == C_LD)
                        w_prox = E_ESCRITA;
                    else
                        w_prox = E_BUSCA;
                end else if (r_saida.mem_req) begin
                    if (r_cnt == LIMITE)
                        w_prox = E_ERRO;
                    else
                        w_cnt_prox = r_cnt + CW'(1);
                end
            end
            E_DECODIFICA: begin
                if (w_classe == C_HALT)
                    w_prox = E_HALT;
                else if (w_classe == C_INV)
                    w_prox = E_ERRO;
                else
                    w_prox = E_EXECUTA;
            end
            E_EXECUTA: begin
                if (w_classe == C_ALU || w_classe == C_JAL)
                    w_prox = E_ESCRITA;
                else if (w_classe == C_LD || w_classe == C_ST)
                    w_prox = E_MEMORIA;
                else
                    w_prox = E_BUSCA;
            end
            E_ESCRITA: w_prox = E_BUSCA;
            default:   w_prox = r_estado;
        endcase

        if (w_prox inside {E_DECODIFICA, E_EXECUTA, E_MEMORIA, E_ESCRITA}) begin
            w_saida.br_sel_e_sa  = w_ir_prox[11:9];
            w_saida.br_sel_sb    = w_ir_prox[8:6];
            w_saida.ex_controle  = w_ex;
            w_saida.ex_constante = w_ir_prox[11:0];
        end
        if (w_prox inside {E_EXECUTA, E_MEMORIA, E_ESCRITA})
            w_saida.ula_op = w_ula_op;

        unique case (w_prox)
            E_BUSCA: begin
                w_saida.mem_req = 1'b1;
                // PC strobe for branches, NOP and ST rides on the first fetch cycle
                if (r_estado == E_EXECUTA || r_estado == E_MEMORIA) begin
                    w_saida.pc_load = 1'b1;
                    if (w_classe == C_JMP || (w_classe == C_BEQZ && ctl.ula_zero))
                        w_saida.pc_sel = PC_DESVIO;
                end
            end
            E_DECODIFICA: w_saida.ir_load = 1'b1;
            E_MEMORIA: begin
                w_saida.mem_req      = 1'b1;
                w_saida.mem_sel_dado = 1'b1;
                w_saida.mem_we       = (w_classe == C_ST);
            end
            E_ESCRITA: begin
                w_saida.br_hab_escrita = 1'b1;
                w_saida.pc_load        = 1'b1;
                w_saida.pc_sel         = PC_MAIS1;
                w_saida.mux_controle   = w_mux;
                if (w_classe == C_JAL)
                    w_saida.br_sel_e_sa = REG_LINK;
            end
            E_HALT:  w_saida.halt = 1'b1;
            E_ERRO:  w_saida.erro = 1'b1;
            default: ;
        endcase
    end

    assign ctl.mem_req        = r_saida.mem_req;
    assign ctl.mem_we         = r_saida.mem_we;
    assign ctl.mem_sel_dado   = r_saida.mem_sel_dado;
    assign ctl.ir_load        = r_saida.ir_load;
    assign ctl.pc_load        = r_saida.pc_load;
    assign ctl.pc_sel         = r_saida.pc_sel;
    assign ctl.br_hab_escrita = r_saida.br_hab_escrita;
    assign ctl.br_sel_e_sa    = r_saida.br_sel_e_sa;
    assign ctl.br_sel_sb      = r_saida.br_sel_sb;
    assign ctl.ex_controle    = r_saida.ex_controle;
    assign ctl.ex_constante   = r_saida.ex_constante;
    assign ctl.mux_controle   = r_saida.mux_controle;
    assign ctl.ula_op         = r_saida.ula_op;
    assign ctl.halt           = r_saida.halt;
    assign ctl.erro           = r_saida.erro;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Bench for unidade_controle_multiciclo: per-instruction timeline
// model (fetch/decode/execute/memory/write cycles) with random waits.
module tb_unidade_controle_multiciclo;
    import unidade_controle_pkg::*;

    logic clock;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;
    logic       pend_load;
    logic [1:0] pend_sel;

    unidade_controle_multiciclo_if bus ();

    unidade_controle_multiciclo #(
        .MEM_TIMEOUT (15),
        .REG_LINK    (3'd7)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .ctl     (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic logic [2:0] exp_ext(input logic [3:0] op);
        case (op)
            4'h5:       return EXT_SINAL6;
            4'h6:       return EXT_ALTO8;
            4'h9:       return EXT_SINAL9;
            4'hA, 4'hB: return EXT_SINAL12;
            default:    return EXT_ZERO6;
        endcase
    endfunction

    function automatic logic [2:0] exp_ula(input logic [3:0] op);
        case (op)
            4'h2:    return ULA_SUB;
            4'h3:    return ULA_AND;
            4'h4:    return ULA_OR;
            4'h6:    return ULA_PASSA_B;
            default: return ULA_ADD;
        endcase
    endfunction

    function automatic logic [11:0] obs_ctl();
        return {bus.mem_req, bus.mem_we, bus.mem_sel_dado, bus.ir_load,
                bus.pc_load, bus.pc_sel, bus.br_hab_escrita,
                bus.mux_controle, bus.halt, bus.erro};
    endfunction

    task automatic do_reset();
        logic [35:0] obs;
        #2 reset_n = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.ula_zero  = 1'b0;
        bus.mem_rdata = 16'h0;
        #1;
        obs = {bus.mem_req, bus.mem_we, bus.mem_sel_dado, bus.ir_load,
               bus.pc_load, bus.pc_sel, bus.br_hab_escrita, bus.br_sel_e_sa,
               bus.br_sel_sb, bus.ex_controle, bus.ex_constante,
               bus.mux_controle, bus.ula_op, bus.halt, bus.erro};
        total++;
        if (obs !== 36'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", obs);
        end
        @(posedge clock);
        #2 reset_n = 1'b1;
        pend_load = 1'b0;
        pend_sel  = 2'b00;
    endtask

    // Drives one instruction from its first fetch cycle and checks every cycle
    task automatic run_instr(input logic [15:0] ir, input int wf, input int wm,
                             input logic zero, input int abort_k);
        logic [3:0]  op;
        logic        is_alu, is_ld, is_st, is_mem, is_jal, is_halt, is_inv, is_fluxo;
        logic        abortou;
        int          d, e, n, w, mfim;
        logic [11:0] exp;
        logic [20:0] fobs, fexp;
        op       = ir[15:12];
        is_alu   = (op >= 4'h1 && op <= 4'h6);
        is_ld    = (op == 4'h7);
        is_st    = (op == 4'h8);
        is_mem   = is_ld || is_st;
        is_jal   = (op == 4'hB);
        is_halt  = (op == 4'hF);
        is_inv   = (op >= 4'hC && op <= 4'hE);
        is_fluxo = (op == 4'h0 || op == 4'h9 || op == 4'hA);
        abortou  = 1'b0;
        d    = wf + 2;
        e    = d + 1;
        mfim = e + 1 + wm;
        w    = 0;
        if (is_halt || is_inv)      n = d + 3;
        else if (is_alu || is_jal) begin n = e + 1; w = n; end
        else if (is_ld)            begin n = e + 2 + wm; w = n; end
        else if (is_st)            n = mfim;
        else                       n = e;

        for (int k = 1; k <= n; k++) begin
            @(posedge clock);
            #1;
            exp = '0;
            if (k < d) begin
                exp[11] = 1'b1;
                if (k == 1) begin
                    exp[7]   = pend_load;
                    exp[6:5] = pend_sel;
                end
            end
            if (k == d) exp[8] = 1'b1;
            if (is_halt && k > d) exp[1] = 1'b1;
            if (is_inv && k > d)  exp[0] = 1'b1;
            if (is_mem && k > e && k <= mfim) begin
                exp[11] = 1'b1;
                exp[10] = is_st;
                exp[9]  = 1'b1;
            end
            if (k == w) begin
                exp[7]   = 1'b1;
                exp[4]   = 1'b1;
                exp[3:2] = is_ld ? 2'b01 : (is_jal ? 2'b10 : 2'b00);
            end
            total++;
            if (obs_ctl() !== exp) begin
                bad++;
                $display("FAIL ctl ir=%h k=%0d: got %b want %b", ir, k, obs_ctl(), exp);
            end
            if (k == e && !is_halt && !is_inv) begin
                fobs = {bus.br_sel_e_sa, bus.br_sel_sb, bus.ex_controle, bus.ex_constante};
                fexp = {ir[11:9], ir[8:6], exp_ext(op), ir[11:0]};
                total++;
                if (fobs !== fexp) begin
                    bad++;
                    $display("FAIL fields ir=%h: got %h want %h", ir, fobs, fexp);
                end
                if (is_alu) begin
                    total++;
                    if (bus.ula_op !== exp_ula(op)) begin
                        bad++;
                        $display("FAIL ula_op ir=%h: got %0d want %0d", ir, bus.ula_op, exp_ula(op));
                    end
                end
            end
            if (k == w && is_jal) begin
                total++;
                if (bus.br_sel_e_sa !== 3'd7) begin
                    bad++;
                    $display("FAIL jal_link: got %0d want 7", bus.br_sel_e_sa);
                end
            end
            if (k == abort_k) begin
                abortou = 1'b1;
                bus.mem_ack = 1'b0;
                break;
            end
            bus.mem_rdata = 16'($urandom);
            bus.ula_zero  = (k == e) ? zero : 1'($urandom_range(0, 1));
            if (k == d - 1) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = ir;
            end else if (is_mem && k == mfim) begin
                bus.mem_ack = 1'b1;
            end else if (exp[11]) begin
                bus.mem_ack = 1'b0;
            end else begin
                bus.mem_ack = 1'($urandom_range(0, 1));
            end
        end
        if (!abortou) begin
            pend_load = is_st || is_fluxo;
            pend_sel  = (op == 4'hA || (op == 4'h9 && zero)) ? 2'b01 : 2'b00;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        do_reset();
    endtask

    task automatic test_alu();
        run_instr(16'h14C0, 0, 0, 1'b0, 0);
        run_instr(16'h2A40, 1, 0, 1'b0, 0);
        run_instr(16'h5E3F, 0, 0, 1'b0, 0);
        run_instr(16'h6FFF, 2, 0, 1'b0, 0);
    endtask

    task automatic test_memoria();
        run_instr(16'h7340, 0, 3, 1'b0, 0);
        run_instr(16'h8A80, 0, 0, 1'b0, 0);
        run_instr(16'h8140, 2, 1, 1'b0, 0);
        run_instr(16'h1000, 0, 0, 1'b0, 0);
    endtask

    task automatic test_desvio();
        run_instr(16'h99FE, 0, 0, 1'b1, 0);
        run_instr(16'h99FE, 0, 0, 1'b0, 0);
        run_instr(16'hA123, 1, 0, 1'b0, 0);
        run_instr(16'h0000, 0, 0, 1'b1, 0);
        run_instr(16'hB010, 0, 0, 1'b0, 0);
    endtask

    task automatic test_reset_mid_ld();
        run_instr(16'h7340, 0, 5, 1'b0, 5);
        do_reset();
        run_instr(16'h14C0, 0, 0, 1'b0, 0);
    endtask

    task automatic test_wait_limit();
        run_instr(16'h7340, 14, 14, 1'b0, 0);
        run_instr(16'h8340, 14, 14, 1'b0, 0);
        run_instr(16'h3100, 0, 0, 1'b0, 0);
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [15:0] ir;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 11));
            ir = {op, 12'($urandom)};
            run_instr(ir, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 0);
        end
    endtask

    task automatic test_halt();
        do_reset();
        run_instr(16'h1240, 0, 0, 1'b0, 0);
        run_instr(16'hF000, 1, 0, 1'b0, 0);
    endtask

    task automatic test_invalido();
        do_reset();
        run_instr(16'hC000, 0, 0, 1'b0, 0);
        do_reset();
        run_instr(16'hE5A5, 2, 0, 1'b0, 0);
    endtask

    task automatic test_timeout();
        logic [11:0] exp;
        do_reset();
        for (int k = 1; k <= 19; k++) begin
            @(posedge clock);
            #1;
            exp = '0;
            if (k <= 15) exp[11] = 1'b1;
            else         exp[0]  = 1'b1;
            total++;
            if (obs_ctl() !== exp) begin
                bad++;
                $display("FAIL timeout k=%0d: got %b want %b", k, obs_ctl(), exp);
            end
            bus.mem_ack = (k <= 15) ? 1'b0 : 1'b1;
        end
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        bus.mem_ack   = 1'b0;
        bus.ula_zero  = 1'b0;
        bus.mem_rdata = 16'h0;
        pend_load     = 1'b0;
        pend_sel      = 2'b00;
        test_reset();
        test_alu();
        test_memoria();
        test_desvio();
        test_reset_mid_ld();
        test_wait_limit();
        test_random();
        test_halt();
        test_invalido();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
